letreiro_scroll_ctrl: RTL

- Sequencer for the 8-digit HEX marquee. Holds a programmable message of up to 16 character codes and generates a scroll tick from CLOCK_50.
- Advances a wrap-around offset under a run/pause/single-step state machine.
- Presents the 8-character window to be decoded onto HEX7..HEX0.
- Replaces the fixed free-running 3-bit counter plus hardwired per-digit decoders with a configurable controller feeding one shared decoder per digit.

---
 rtl/letreiro_pkg.sv | 42 ++++
 rtl/letreiro_tick.sv | 35 +++
 rtl/letreiro_scroll_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/letreiro_pkg.sv
// letreiro_pkg
//   Shared types and constants for the HEX marquee scroll controller.
//   - state_t     : controller state (IDLE / RUN / PAUSE)
//   - MSG_MAX, CHAR_W, ADDR_W, LEN_W, NUM_DIG : buffer and window geometry
//   - BLANK_ALL / BLANK_NONE : per-digit blank masks
//   - CH_* : character codes understood by the per-digit decoder
//   - eff_len() : clamps the programmed message length to 1..MSG_MAX
package letreiro_pkg;

    localparam int MSG_MAX = 16;
    localparam int CHAR_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int LEN_W   = 5;
    localparam int NUM_DIG = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [NUM_DIG-1:0] BLANK_ALL  = 8'hFF;
    localparam logic [NUM_DIG-1:0] BLANK_NONE = 8'h00;

    // Character codes as interpreted by the shared 7-segment decoder.
    localparam logic [CHAR_W-1:0] CH_0 = 4'h0;
    localparam logic [CHAR_W-1:0] CH_9 = 4'h9;
    localparam logic [CHAR_W-1:0] CH_A = 4'hA;
    localparam logic [CHAR_W-1:0] CH_F = 4'hF;

    // Length 0 behaves as a one-character message; anything past the
    // buffer depth is clipped to the full buffer.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] n);
        if (n == '0)
            return LEN_W'(1);
        else if (n > LEN_W'(MSG_MAX))
            return LEN_W'(MSG_MAX);
        else
            return n;
    endfunction

endpackage

// File: rtl/letreiro_tick.sv
// letreiro_tick
//   Loadable prescaler. Counts enabled cycles and pulses tick on the cycle
//   the count reaches period-1, then restarts from 0. The period may change
//   at any time; a count already at or past the new limit fires at once.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     period     : cycles per tick (>= 1)
//     en         : count enable
//     clr        : synchronous clear, also suppresses tick
//     tick       : combinational one-cycle pulse
module letreiro_tick #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] period,
    input  logic             en,
    input  logic             clr,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;

    assign tick = en && !clr && (cnt >= period - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/letreiro_scroll_ctrl.sv
// letreiro_scroll_ctrl
//   Sequencer for the 8-digit HEX marquee: holds a message of up to 16
//   characters, scrolls a wrap-around offset under a run/pause/single-step
//   FSM and registers the 8-character window for the per-digit decoders.
//   Ports:
//     CLOCK_50, reset              : 50 MHz clock, asynchronous active-low reset
//     cmd_start/cmd_stop/cmd_step  : one-cycle command pulses (stop > start > step)
//     dir                          : 0 = offset+1, 1 = offset-1
//     spd                          : step period = TICK_BASE << spd
//     msg_len                      : active message length (0 -> 1, >16 -> 16)
//     wr_en/wr_addr/wr_data        : message buffer write port
//     win                          : window, top character = HEX7
//     win_blank                    : per-digit blank mask, bit 7 = HEX7
//     offset                       : current scroll offset
//     busy                         : high while in RUN
//   Build option: LETREIRO_PAUSE_BLINK_EN makes the display blink while
//   paused (blank phase first, toggling every TICK_BASE<<1 cycles).
module letreiro_scroll_ctrl #(
    parameter int TICK_BASE = 12500000,
    parameter int MSG_MAX   = 16,
    parameter int CHAR_W    = 4
) (
    input  logic                           CLOCK_50,
    input  logic                           reset,
    input  logic                           cmd_start,
    input  logic                           cmd_stop,
    input  logic                           cmd_step,
    input  logic                           dir,
    input  logic [1:0]                     spd,
    input  logic [4:0]                     msg_len,
    input  logic                           wr_en,
    input  logic [letreiro_pkg::ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0]              wr_data,
    output logic [8*CHAR_W-1:0]            win,
    output logic [7:0]                     win_blank,
    output logic [letreiro_pkg::ADDR_W-1:0] offset,
    output logic                           busy
);
    import letreiro_pkg::*;

    // Wide enough for the slowest period (TICK_BASE << 3).
    localparam int CNT_W = $clog2((TICK_BASE << 3) + 1);

    state_t state, state_nx;
    logic   do_step;
    logic   tick_en, tick_clr, step_tick;

    logic [CHAR_W-1:0]  msg [MSG_MAX];
    logic [LEN_W-1:0]   len;
    logic [CNT_W-1:0]   step_period;

    logic [8*CHAR_W-1:0] win_nx;
    logic [7:0]          blank_nx;
    logic [LEN_W-1:0]    pos;
    logic [ADDR_W-1:0]   idx;

    assign len         = eff_len(msg_len);
    assign step_period = CNT_W'(TICK_BASE) << spd;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    // A stop with nothing to stop (IDLE, PAUSE) still masks start/step.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (!cmd_stop) begin
                    if (cmd_start)     state_nx = RUN;
                    else if (cmd_step) state_nx = PAUSE;
                end
            end
            RUN: begin
                if (cmd_stop) state_nx = PAUSE;
            end
            PAUSE: begin
                if (!cmd_stop && cmd_start) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Any state change clears the prescaler, which also swallows a tick that
    // coincides with a stop.
    always_comb begin
        tick_en  = (state == RUN);
        tick_clr = (state_nx != state);
        do_step  = 1'b0;
        unique case (state)
            IDLE:    do_step = !cmd_stop && !cmd_start && cmd_step;
            RUN:     do_step = step_tick;
            PAUSE:   do_step = !cmd_stop && !cmd_start && cmd_step;
            default: do_step = 1'b0;
        endcase
    end

    letreiro_tick #(.CNT_W(CNT_W)) u_step_tick (
        .clk    (CLOCK_50),
        .rst_n  (reset),
        .period (step_period),
        .en     (tick_en),
        .clr    (tick_clr),
        .tick   (step_tick)
    );

    // ---------------- offset ----------------
    // An out-of-range offset (length just shrank) snaps to 0 before any step.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            offset <= '0;
        else if ({1'b0, offset} >= len)
            offset <= '0;
        else if (do_step) begin
            if (dir)
                offset <= (offset == '0) ? ADDR_W'(len - LEN_W'(1)) : offset - ADDR_W'(1);
            else
                offset <= ({1'b0, offset} + LEN_W'(1) == len) ? '0 : offset + ADDR_W'(1);
        end
    end

    // ---------------- message buffer (not reset) ----------------
    always_ff @(posedge CLOCK_50) begin
        if (wr_en)
            msg[wr_addr] <= wr_data;
    end

    // ---------------- window ----------------
    // Digit 0 (HEX7) shows msg[offset]; short messages repeat across the window.
    always_comb begin
        win_nx = '0;
        pos    = '0;
        idx    = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            pos = {1'b0, offset} + LEN_W'(i);
            idx = ADDR_W'(pos % len);
            win_nx[(NUM_DIG-1-i)*CHAR_W +: CHAR_W] = msg[idx];
        end
    end

`ifdef LETREIRO_PAUSE_BLINK_EN
    logic blink_tick;
    logic blink_ph, blink_ph_nx;

    letreiro_tick #(.CNT_W(CNT_W)) u_blink_tick (
        .clk    (CLOCK_50),
        .rst_n  (reset),
        .period (CNT_W'(TICK_BASE) << 1),
        .en     (state == PAUSE),
        .clr    (state_nx != state),
        .tick   (blink_tick)
    );

    // Phase 1 = blanked; every entry into PAUSE starts blanked.
    assign blink_ph_nx = (state != PAUSE) ? 1'b1 :
                         (blink_tick ? ~blink_ph : blink_ph);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            blink_ph <= 1'b1;
        else
            blink_ph <= blink_ph_nx;
    end
`endif

    // Blank mask follows the state being entered so it lines up with busy.
    always_comb begin
        blank_nx = BLANK_ALL;
        unique case (state_nx)
            IDLE: blank_nx = BLANK_ALL;
            RUN:  blank_nx = BLANK_NONE;
`ifdef LETREIRO_PAUSE_BLINK_EN
            PAUSE: blank_nx = {8{blink_ph_nx}};
`else
            PAUSE: blank_nx = BLANK_NONE;
`endif
            default: blank_nx = BLANK_ALL;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            win       <= '0;
            win_blank <= BLANK_ALL;
            busy      <= 1'b0;
        end else begin
            win       <= win_nx;
            win_blank <= blank_nx;
            busy      <= (state_nx == RUN);
        end
    end

endmodule
